// File: rtl/mmss_countdown.sv
// mm:ss countdown timer with run/pause, preset load and Fischer increment.
// Expiry is sticky until a load or reset.
module mmss_countdown #(
  parameter int SEC_MOD = 60,
  parameter int MAX_MIN = 99,
  parameter int MIN_W = 7,
  parameter int INC_SEC = 0,
  localparam int SEC_W = $clog2(SEC_MOD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             run,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             add_inc,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             borrow,
  output logic             expired,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_EXP   = 2'd3
  } state_t;

  localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SEC_MOD - 1);
  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MAX_MIN);
  localparam logic [SEC_W:0]   INC_V = (SEC_W+1)'(INC_SEC);
  localparam logic [SEC_W:0]   MOD_V = (SEC_W+1)'(SEC_MOD);
  localparam logic [MIN_W:0]   MAXM_V = (MIN_W+1)'(MAX_MIN);

  state_t           r_state, w_state_nxt;
  logic [MIN_W-1:0] r_min, w_min_nxt;
  logic [SEC_W-1:0] r_sec, w_sec_nxt;
  logic             r_borrow, w_borrow_nxt;
  logic             r_expired, w_expired_nxt;

  logic [MIN_W-1:0] w_dec_min, w_base_min, w_inc_min, w_ld_min;
  logic [SEC_W-1:0] w_dec_sec, w_base_sec, w_inc_sec, w_ld_sec;
  logic [MIN_W:0]   w_min_carry;
  logic [SEC_W:0]   w_sum;
  logic             w_wrap, w_dec_zero, w_time_zero, w_do_tick;

  always_comb begin
    w_dec_min = r_min;
    w_dec_sec = r_sec;
    w_wrap    = 1'b0;
    if (r_sec != '0) begin
      w_dec_sec = r_sec - SEC_W'(1);
    end else if (r_min != '0) begin
      w_dec_sec = SEC_TOP;
      w_dec_min = r_min - MIN_W'(1);
      w_wrap    = 1'b1;
    end
  end

  assign w_dec_zero  = (w_dec_min == '0) && (w_dec_sec == '0);
  assign w_time_zero = (r_min == '0) && (r_sec == '0);
  assign w_do_tick   = (r_state == S_RUN) && tick;

  // Increment is applied on top of this cycle's decrement, if any
  assign w_base_min = w_do_tick ? w_dec_min : r_min;
  assign w_base_sec = w_do_tick ? w_dec_sec : r_sec;

  always_comb begin
    w_sum       = {1'b0, w_base_sec} + INC_V;
    w_min_carry = {1'b0, w_base_min};
    w_inc_sec   = w_sum[SEC_W-1:0];
    if (w_sum >= MOD_V) begin
      w_inc_sec   = SEC_W'(w_sum - MOD_V);
      w_min_carry = {1'b0, w_base_min} + (MIN_W+1)'(1);
    end
    w_inc_min = w_min_carry[MIN_W-1:0];
    if (w_min_carry > MAXM_V) begin
      w_inc_min = MIN_TOP;
      w_inc_sec = SEC_TOP;
    end
  end

  assign w_ld_min = (load_min > MIN_TOP) ? MIN_TOP : load_min;
  assign w_ld_sec = (load_sec > SEC_TOP) ? SEC_TOP : load_sec;

  always_comb begin
    w_state_nxt   = r_state;
    w_min_nxt     = r_min;
    w_sec_nxt     = r_sec;
    w_borrow_nxt  = 1'b0;
    w_expired_nxt = r_expired;
    if (load) begin
      w_state_nxt   = S_IDLE;
      w_min_nxt     = w_ld_min;
      w_sec_nxt     = w_ld_sec;
      w_expired_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (run && w_time_zero) begin
            w_state_nxt   = S_EXP;
            w_expired_nxt = 1'b1;
          end else if (run) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          w_state_nxt = run ? S_RUN : S_PAUSE;
          if (tick) begin
            w_min_nxt    = w_dec_min;
            w_sec_nxt    = w_dec_sec;
            w_borrow_nxt = w_wrap;
          end
          if (tick && w_dec_zero) begin
            w_state_nxt   = S_EXP;
            w_expired_nxt = 1'b1;
          end else if (add_inc) begin
            w_min_nxt = w_inc_min;
            w_sec_nxt = w_inc_sec;
          end
        end
        S_PAUSE: begin
          if (run) w_state_nxt = S_RUN;
          if (add_inc) begin
            w_min_nxt = w_inc_min;
            w_sec_nxt = w_inc_sec;
          end
        end
        S_EXP: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_min     <= '0;
      r_sec     <= '0;
      r_borrow  <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_min     <= w_min_nxt;
      r_sec     <= w_sec_nxt;
      r_borrow  <= w_borrow_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  assign minutes = r_min;
  assign seconds = r_sec;
  assign borrow  = r_borrow;
  assign expired = r_expired;
  assign state   = r_state;

endmodule

// File: doc/mmss_countdown.md
MMSS_COUNTDOWN -- requirements
Module: mmss_countdown

Interface
REQ-001 The block SHALL have parameter SEC_MOD, default 60: seconds modulus; seconds count SEC_MOD-1 down to 0.
REQ-002 The block SHALL have parameter MAX_MIN, default 99: largest minutes value held.
REQ-003 The block SHALL have parameter MIN_W, default 7: minutes width, with 2^MIN_W > MAX_MIN.
REQ-004 The block SHALL have parameter INC_SEC, default 0: Fischer increment in seconds, with 0 <= INC_SEC < SEC_MOD.
REQ-005 The block SHALL use SEC_W = clog2(SEC_MOD) as a derived width.
REQ-006 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 The block SHALL have port tick, input, 1: one-clk-wide 1 Hz strobe.
REQ-009 The block SHALL have port run, input, 1: level; 1 means count, 0 means hold.
REQ-010 The block SHALL have port load, input, 1: pulse; preset time from load_min/load_sec.
REQ-011 The block SHALL have port load_min, input, MIN_W: preset minutes.
REQ-012 The block SHALL have port load_sec, input, SEC_W: preset seconds.
REQ-013 The block SHALL have port add_inc, input, 1: pulse; add INC_SEC seconds (end of move).
REQ-014 The block SHALL have port minutes, output, MIN_W: current minutes.
REQ-015 The block SHALL have port seconds, output, SEC_W: current seconds.
REQ-016 The block SHALL have port borrow, output, 1: one-clk pulse on each seconds wrap 0 to SEC_MOD-1.
REQ-017 The block SHALL have port expired, output, 1: sticky flag set when time reaches 0:00 while running.
REQ-018 The block SHALL have port state, output, 2: state code, with IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.

Function
REQ-019 All outputs SHALL be registered; every response appears on the clk edge after the causing input is sampled.
REQ-020 The state machine SHALL have states IDLE, RUN, PAUSE and EXPIRED.
REQ-021 IDLE SHALL go to RUN when run=1 and time != 0:00, and to EXPIRED (expired=1) when run=1 and time = 0:00.
REQ-022 RUN SHALL go to PAUSE when run=0, and PAUSE SHALL go to RUN when run=1.
REQ-023 EXPIRED SHALL be left only by load or reset.
REQ-024 In RUN with tick=1 and seconds > 0, seconds SHALL decrement by 1.
REQ-025 In RUN with tick=1, seconds = 0 and minutes > 0, seconds SHALL become SEC_MOD-1, minutes SHALL decrement by 1, and borrow SHALL be 1 for one cycle.
REQ-026 When a tick in RUN makes the time 0:00, the next state SHALL be EXPIRED with expired=1 on that same edge.
REQ-027 Ticks in IDLE, PAUSE or EXPIRED SHALL be ignored, with no count change and no borrow.
REQ-028 A tick coinciding with run falling in RUN SHALL still be applied on that edge, and the state SHALL become PAUSE.
REQ-029 add_inc in RUN or PAUSE SHALL add INC_SEC to seconds; a sum >= SEC_MOD SHALL wrap seconds by -SEC_MOD and carry 1 into minutes.
REQ-030 An add_inc result above MAX_MIN:(SEC_MOD-1) SHALL saturate at MAX_MIN:(SEC_MOD-1).
REQ-031 add_inc in IDLE or EXPIRED SHALL be ignored.
REQ-032 When tick and add_inc occur together in RUN, the decrement SHALL be applied first and then the increment.
REQ-033 If that decrement reaches 0:00, expiry SHALL win and the increment SHALL be discarded.
REQ-034 load SHALL take effect in any state on the next edge: minutes = min(load_min, MAX_MIN), seconds = min(load_sec, SEC_MOD-1), state = IDLE, expired = 0, borrow = 0.
REQ-035 load SHALL have priority over run, tick and add_inc in the same cycle.
REQ-036 With INC_SEC=0, add_inc SHALL have no effect on the count.

Reset
REQ-037 reset=1 at a clk edge SHALL force minutes=0, seconds=0, state=IDLE, borrow=0 and expired=0, overriding all other inputs, including mid-count.
REQ-038 After reset, the block SHALL remain in IDLE until load or run.

Verification
REQ-039 Load 1:00, run=1, apply 1 tick: the response SHALL be 0:59 with borrow pulsed for exactly one cycle.
REQ-040 Load 0:02, run=1, apply 2 ticks: the response SHALL be 0:00 and EXPIRED with expired=1; further ticks and add_inc SHALL leave 0:00.
REQ-041 With INC_SEC=5, load 0:57 and pulse add_inc in PAUSE: the response SHALL be 1:02 with no borrow.
REQ-042 With INC_SEC=5, load 99:58 and pulse add_inc in RUN: the response SHALL be 99:59 (saturated).
REQ-043 Load 0:01, run=1, with tick and add_inc in the same cycle: the response SHALL be 0:00 and EXPIRED, with the increment discarded.
REQ-044 In RUN at 5:30, assert reset together with tick and load: the response SHALL be 0:00 and IDLE with all flags 0; load_min=120 then SHALL clamp to 99.
